// File: rtl/mac_pkg.sv
// Shared types and default dimensions for the MAC array.
package mac_pkg;

  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;
  localparam int COL_DEF     = 8;
  localparam int LEN_BW_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: registered unsigned*signed product, then a wrap/saturate accumulator.
module mac_lane #(
  parameter int bw      = mac_pkg::BW_DEF,
  parameter int psum_bw = mac_pkg::PSUM_BW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               add_en,
  input  logic               sat_en,
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  output logic [psum_bw-1:0] acc
);

  logic [psum_bw-1:0] prod_reg;
  logic [psum_bw-1:0] prod_next;
  logic [psum_bw-1:0] acc_reg;
  logic [psum_bw-1:0] acc_next;
  logic [psum_bw:0]   sum_full;
  logic               pos_ovf;
  logic               neg_ovf;

  // The exact product fits in 2*bw signed bits, so computing at psum_bw is lossless.
  assign prod_next = $signed({{(psum_bw-bw){1'b0}}, a}) *
                     $signed({{(psum_bw-bw){b[bw-1]}}, b});

  assign sum_full = {acc_reg[psum_bw-1], acc_reg} + {prod_reg[psum_bw-1], prod_reg};
  assign pos_ovf  = (sum_full[psum_bw -: 2] == 2'b01);
  assign neg_ovf  = (sum_full[psum_bw -: 2] == 2'b10);

  always_comb begin
    acc_next = sum_full[psum_bw-1:0];
    if (sat_en && pos_ovf) begin
      acc_next = {1'b0, {(psum_bw-1){1'b1}}};
    end else if (sat_en && neg_ovf) begin
      acc_next = {1'b1, {(psum_bw-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg <= '0;
      acc_reg  <= '0;
    end else begin
      if (load) begin
        prod_reg <= prod_next;
      end
      if (clear) begin
        acc_reg <= '0;
      end else if (add_en) begin
        acc_reg <= acc_next;
      end
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/mac_array.sv
// col-lane MAC array: job FSM and beat counter here, per-lane datapath in mac_lane.
module mac_array
  import mac_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int col     = COL_DEF,
  parameter int len_bw  = LEN_BW_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [len_bw-1:0]      len,
  input  logic                   sat_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [col*bw-1:0]      a,
  input  logic [col*bw-1:0]      b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [col*psum_bw-1:0] out,
  output logic                   busy
);

  state_t             state_reg;
  state_t             state_next;
  logic [len_bw-1:0]  cnt_reg;
  logic [len_bw-1:0]  len_reg;
  logic               sat_reg;
  logic               prod_vld_reg;
  logic               start_ok;
  logic               accept;
  logic               last_beat;

  assign start_ok  = (state_reg == ST_IDLE) && start && (len != '0);
  assign accept    = (state_reg == ST_ACC) && in_valid;
  assign last_beat = ((cnt_reg + len_bw'(1)) == len_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start_ok) state_next = ST_ACC;
      ST_ACC:   if (accept && last_beat) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      len_reg      <= '0;
      sat_reg      <= 1'b0;
      prod_vld_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // A product loaded on this edge is folded into the accumulator on the next.
      prod_vld_reg <= accept;
      if (start_ok) begin
        cnt_reg <= '0;
        len_reg <= len;
        sat_reg <= sat_en;
      end else if (accept) begin
        cnt_reg <= cnt_reg + len_bw'(1);
      end
    end
  end

  assign in_ready  = (state_reg == ST_ACC);
  assign out_valid = (state_reg == ST_HOLD);
  assign busy      = (state_reg != ST_IDLE);

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
      mac_lane #(
        .bw      (bw),
        .psum_bw (psum_bw)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_ok),
        .load    (accept),
        .add_en  (prod_vld_reg),
        .sat_en  (sat_reg),
        .a       (a[gi*bw +: bw]),
        .b       (b[gi*bw +: bw]),
        .acc     (out[gi*psum_bw +: psum_bw])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench: two arrays (16-bit and 8-bit sums) share stimulus; an arithmetic model predicts lane sums.
module tb_mac_array;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   len = '0;
  logic         sat_en = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  a_in = '0;
  logic [31:0]  b_in = '0;
  logic         out_ready = 1'b0;

  logic         in_ready16, out_valid16, busy16;
  logic         in_ready8, out_valid8, busy8;
  logic [127:0] out16;
  logic [63:0]  out8;

  int checks = 0;
  int passes = 0;

  logic [31:0]  job_a[$];
  logic [31:0]  job_b[$];
  logic [127:0] q16[$];
  logic [63:0]  q8[$];
  logic [127:0] held16;
  bit           have_hold = 0;

  always #5 clk = ~clk;

  mac_array #(.bw(4), .psum_bw(16), .col(8), .len_bw(8)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a_in), .b(b_in),
    .out_valid(out_valid16), .out_ready(out_ready), .out(out16), .busy(busy16)
  );

  mac_array #(.bw(4), .psum_bw(8), .col(8), .len_bw(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready8), .a(a_in), .b(b_in),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8), .busy(busy8)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Plain integer arithmetic over the queued beats, lanes packed at w bits each.
  function automatic logic [127:0] model(input int w, input bit sat);
    logic [127:0] res = '0;
    longint maxv = (longint'(1) << (w - 1)) - 1;
    longint minv = -(longint'(1) << (w - 1));
    for (int k = 0; k < 8; k++) begin
      longint acc = 0;
      for (int i = 0; i < job_a.size(); i++) begin
        longint av = longint'((job_a[i] >> (4 * k)) & 32'hF);
        longint bv = longint'((job_b[i] >> (4 * k)) & 32'hF);
        if (bv >= 8) bv -= 16;
        acc += av * bv;
        if (sat) begin
          if (acc > maxv) acc = maxv;
          if (acc < minv) acc = minv;
        end else begin
          acc = acc & ((longint'(1) << w) - 1);
          if (acc > maxv) acc -= (longint'(1) << w);
        end
      end
      res |= ((128'(acc)) & ((128'd1 << w) - 1)) << (k * w);
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (out_valid16 && out_ready) begin
      if (q16.size() == 0 || q8.size() == 0) begin
        chk("unexpected_result", 128'(q16.size()), 128'd1);
      end else begin
        chk("out16", out16, q16.pop_front());
        chk("out8", 128'(out8), 128'(q8.pop_front()));
      end
      have_hold = 0;
    end else if (out_valid16) begin
      if (have_hold) chk("out_stable", out16, held16);
      held16 = out16;
      have_hold = 1;
    end
  end

  task automatic fill_random(input int n);
    job_a.delete();
    job_b.delete();
    for (int i = 0; i < n; i++) begin
      job_a.push_back($urandom);
      job_b.push_back($urandom);
    end
  endtask

  // abort_at > 0 pulses reset after that many accepted beats; poke asserts start mid-job.
  task automatic run_job(input bit sat, input bit gaps, input int hold,
                         input int abort_at, input bit poke);
    int n = job_a.size();
    int got = 0;
    int cyc = 0;
    bit ok;
    logic [127:0] e16 = model(16, sat);
    logic [127:0] e8 = model(8, sat);
    start = 1; len = 8'(n); sat_en = sat;
    @(posedge clk); #1;
    start = 0; len = 8'($urandom); sat_en = ~sat;
    chk("busy_acc", 128'(busy16), 128'd1);
    if (abort_at == 0) begin
      q16.push_back(e16);
      q8.push_back(e8[63:0]);
    end
    while (got < n && cyc < 4 * n + 20) begin
      in_valid = !(gaps && (cyc % 2 == 1));
      a_in = job_a[got];
      b_in = job_b[got];
      if (poke && got == 1) begin
        start = 1; len = 8'd1;
      end
      ok = in_valid && in_ready16;
      @(posedge clk); #1;
      start = 0;
      if (ok) got++;
      cyc++;
      if (abort_at != 0 && got == abort_at) break;
    end
    in_valid = 0;
    if (abort_at != 0) begin
      #2 reset_n = 0;
      #1;
      chk("rst_busy", 128'(busy16), 128'd0);
      chk("rst_in_ready", 128'(in_ready16), 128'd0);
      chk("rst_out_valid", 128'(out_valid16), 128'd0);
      chk("rst_out16", out16, 128'd0);
      chk("rst_out8", 128'(out8), 128'd0);
      @(posedge clk); #1;
      reset_n = 1;
      return;
    end
    if (got < n) begin
      chk("beat_timeout", 128'(got), 128'(n));
      q16.delete(); q8.delete();
      return;
    end
    chk("drain_no_valid", 128'(out_valid16), 128'd0);
    chk("drain_busy", 128'(busy16), 128'd1);
    @(posedge clk); #1;
    chk("valid_latency16", 128'(out_valid16), 128'd1);
    chk("valid_latency8", 128'(out_valid8), 128'd1);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("busy_hold", 128'(busy16), 128'd1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("busy_idle", 128'(busy16), 128'd0);
    chk("out_kept16", out16, e16);
  endtask

  initial begin
    #12;
    chk("reset_busy", 128'(busy16), 128'd0);
    chk("reset_out", out16, 128'd0);
    chk("reset_out_valid", 128'(out_valid8), 128'd0);
    @(posedge clk); #1;
    reset_n = 1;

    // lane 0: 15 * -8 three times
    fill_random(3);
    for (int i = 0; i < 3; i++) begin
      job_a[i][3:0] = 4'hF; job_b[i][3:0] = 4'h8;
    end
    run_job(0, 0, 0, 0, 0);
    chk("wrap16_lane0", 128'(out16[15:0]), 128'h0000_FE98);

    fill_random(2);
    for (int i = 0; i < 2; i++) begin
      job_a[i][3:0] = 4'hF; job_b[i][3:0] = 4'h7;
    end
    run_job(1, 0, 1, 0, 0);
    chk("sat8_pos", 128'(out8[7:0]), 128'h7F);
    run_job(0, 0, 0, 0, 0);
    chk("wrap8_pos", 128'(out8[7:0]), 128'hD2);

    for (int i = 0; i < 2; i++) job_b[i][3:0] = 4'h8;
    run_job(1, 0, 0, 0, 0);
    chk("sat8_neg", 128'(out8[7:0]), 128'h80);
    run_job(0, 0, 0, 0, 0);
    chk("wrap8_neg", 128'(out8[7:0]), 128'h10);

    // gapped input with a slow consumer
    fill_random(4);
    run_job(1, 1, 5, 0, 0);

    // reset mid-job, then a fresh single-beat job
    fill_random(4);
    run_job(0, 0, 0, 2, 0);
    job_a.delete(); job_b.delete();
    job_a.push_back(32'h1111_1111); job_b.push_back(32'h1111_1111);
    run_job(0, 0, 0, 0, 0);
    chk("after_reset_ones", out16, {8{16'h0001}});

    // zero-length start is ignored
    start = 1; len = 0;
    @(posedge clk); #1;
    start = 0;
    chk("len0_busy", 128'(busy16), 128'd0);
    @(posedge clk); #1;
    chk("len0_busy_later", 128'(busy16), 128'd0);

    fill_random(5);
    run_job(0, 0, 0, 0, 1);

    for (int j = 0; j < 8; j++) begin
      fill_random(int'($urandom_range(1, 9)));
      run_job(1'($urandom), 1'($urandom), int'($urandom_range(0, 4)), 0, 1'($urandom));
    end

    @(posedge clk); #1;
    chk("queue_empty", 128'(q16.size() + q8.size()), 128'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 Parameter bw, default 4: width of each activation and weight element.
REQ-002 Parameter psum_bw, default 16: width of each lane's partial sum and output.
REQ-003 Parameter col, default 8: number of parallel MAC lanes.
REQ-004 Parameter len_bw, default 8: width of the job length field.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to begin a job; sampled only in IDLE.
REQ-008 len  input  len_bw  number of input beats in the job; sampled with start.
REQ-009 sat_en  input  1  1 = saturating accumulation, 0 = two's-complement wrap; sampled with start.
REQ-010 in_valid  input  1  a/b beat present.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 a  input  col*bw  unsigned activations; lane k = a[k*bw +: bw].
REQ-013 b  input  col*bw  signed weights; lane k = b[k*bw +: bw].
REQ-014 out_valid  output  1  final sums available.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 out  output  col*psum_bw  signed lane sums; lane k = out[k*psum_bw +: psum_bw].
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, ACC, DRAIN, HOLD; in_ready=1 only in ACC; out_valid=1 only in HOLD.
REQ-019 IDLE: start=1 with len!=0 -> ACC, zero all accumulators, zero beat counter, latch len and sat_en; start with len=0 ignored (stay IDLE).
REQ-020 ACC: beat accepted on an edge with in_valid&&in_ready; counter increments; edge accepting beat number len -> DRAIN; in_valid gaps stall without effect.
REQ-021 Stage 1: each accepted beat registers per-lane product = signed(b) * zero-extended a, sign-extended to psum_bw.
REQ-022 Stage 2: on the edge after a product register loads, that product is added to the lane accumulator.
REQ-023 DRAIN lasts exactly one cycle, then -> HOLD; out_valid rises on the first edge after the last accepting edge.
REQ-024 HOLD: out equals accumulators, stable while out_ready=0; out_valid&&out_ready -> IDLE on that edge.
REQ-025 sat_en=0: sum wraps modulo 2^psum_bw. sat_en=1: sum clamps to 2^(psum_bw-1)-1 on positive overflow, -2^(psum_bw-1) on negative overflow, every addition.
REQ-026 start asserted outside IDLE is ignored; len/sat_en changes outside IDLE have no effect.
REQ-027 out holds last result after returning to IDLE until the next start clears the accumulators.

Reset
REQ-028 reset_n=0 asynchronously forces IDLE, in_ready=0, out_valid=0, busy=0, out=0, counter and product registers 0, from any state, including mid-job; the job is discarded.
REQ-029 First start is honoured on the first rising edge with reset_n=1.

Structure
REQ-030 Shared package mac_pkg holds the FSM state enum and default bw/psum_bw/col/len_bw constants.
REQ-031 One sub-module mac_lane (product register, accumulator, wrap/saturate adder) instantiated col times; FSM and counter live in mac_array.

Verification
REQ-032 Lane 0 a=15, b=-8 (4'b1000), len=3, sat_en=0, psum_bw=16 -> out lane 0 = 16'hFE98 (-360), out_valid one edge after third accept.
REQ-033 psum_bw=8, a=15, b=7, len=2: sat_en=1 -> 8'h7F; sat_en=0 -> 8'hD2.
REQ-034 psum_bw=8, a=15, b=-8, len=2: sat_en=1 -> 8'h80; sat_en=0 -> 8'h10.
REQ-035 len=4 with in_valid low on alternate cycles and out_ready held low 5 cycles -> correct sum, out stable, busy high throughout until handshake.
REQ-036 reset_n pulsed low after 2 of 4 beats -> immediate IDLE, out=0; new job len=1 a=1 b=1 -> all lanes 1.
REQ-037 start with len=0 -> busy stays 0; start during ACC -> ignored, sum unaffected.
